// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// requester ids and the latency counter width.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } arb_state_e;

   localparam logic REQ_IF  = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   // Wide enough for MEM_LAT - 1 with MEM_LAT up to 15.
   localparam int unsigned CntW = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with a zero flag; saturates at zero when decremented.
module mem_port_arbiter_lat_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one fixed-latency memory port.
// Define WB_BUFFER_EN to add a one-entry posted store buffer.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              mem_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [CntW-1:0] LatLoad = CntW'(MEM_LAT - 1);

   arb_state_e        state_q, state_d;
   logic              gnt_id_q, gnt_id_d;
   logic              drop_q, drop_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic              win_req;
   logic              drain_act;
   logic              cnt_zero;

`ifdef WB_BUFFER_EN
   logic              drain_q, drain_d;
   logic              buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;

   assign drain_act = drain_q;
`else
   assign drain_act = 1'b0;
`endif

   mem_port_arbiter_lat_counter #(
      .Width (CntW)
   ) u_lat_counter (
      .clk_i      (Clk),
      .rst_ni     (Reset),
      .load_i     (state_q == StIssue),
      .load_val_i (LatLoad),
      .dec_i      (state_q == StWait),
      .zero_o     (cnt_zero)
   );

   assign win_req = (gnt_id_q == REQ_MEM) ? mem_req : if_req;

   always_comb begin
      state_d     = state_q;
      gnt_id_d    = gnt_id_q;
      drop_d      = drop_q;
      ram_en_d    = 1'b0;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
`ifdef WB_BUFFER_EN
      drain_d     = drain_q;
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
`endif

      unique case (state_q)
         StIdle: begin
`ifdef WB_BUFFER_EN
            drain_d = 1'b0;
            // A pending buffered store drains first so later loads see it.
            if (buf_valid_q) begin
               drain_d     = 1'b1;
               gnt_id_d    = REQ_MEM;
               drop_d      = 1'b0;
               ram_we_d    = 1'b1;
               ram_addr_d  = buf_addr_q;
               ram_wdata_d = buf_data_q;
               ram_en_d    = 1'b1;
               state_d     = StIssue;
            end else if (mem_req && mem_we) begin
               buf_valid_d = 1'b1;
               buf_addr_d  = mem_addr;
               buf_data_d  = mem_wdata;
               mem_done_d  = 1'b1;
            end else
`endif
            if (mem_req) begin
               gnt_id_d    = REQ_MEM;
               drop_d      = 1'b0;
               ram_we_d    = mem_we;
               ram_addr_d  = mem_addr;
               ram_wdata_d = mem_wdata;
               ram_en_d    = 1'b1;
               state_d     = StIssue;
            end else if (if_req) begin
               gnt_id_d    = REQ_IF;
               drop_d      = 1'b0;
               ram_we_d    = 1'b0;
               ram_addr_d  = if_addr;
               ram_en_d    = 1'b1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            // Always pass through WAIT: ram_rdata is valid only MEM_LAT cycles after ISSUE.
            state_d = StWait;
            if (!win_req) drop_d = 1'b1;
         end
         StWait: begin
            if (!win_req) drop_d = 1'b1;
            if (cnt_zero) begin
               state_d = StDone;
               if (win_req && !drop_q && !drain_act) begin
                  if (gnt_id_q == REQ_MEM) begin
                     mem_done_d = 1'b1;
                     if (!ram_we_q) mem_rdata_d = ram_rdata;
                  end else begin
                     if_done_d  = 1'b1;
                     if_rdata_d = ram_rdata;
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
`ifdef WB_BUFFER_EN
            if (drain_q) buf_valid_d = 1'b0;
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= StIdle;
         gnt_id_q    <= REQ_IF;
         drop_q      <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_id_q    <= gnt_id_d;
         drop_q      <= drop_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
      end
   end

`ifdef WB_BUFFER_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         drain_q     <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         drain_q     <= drain_d;
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end
`endif

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_done   = if_done_q;
   assign mem_done  = mem_done_q;
   assign if_stall  = if_req && !if_done_q;
   assign mem_stall = mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with MEM_LAT = 2 and a small memory model.
module tb_mem_port_arbiter;

   typedef struct {
      logic [31:0] data;
      bit          chk;
      int          cyc;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_stall;
   logic        ram_en;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   exp_t if_q[$];
   exp_t mem_q[$];
   exp_t if_e;
   exp_t mem_e;

   logic [31:0] mem [0:255];
   logic [31:0] pipe1;

   mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (2)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .mem_stall (mem_stall),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial forever #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Memory model: read data appears two cycles after the ram_en cycle.
   always @(posedge Clk) begin
      if (!Reset) begin
         mem[16]  <= 32'h8C02_0004;
         mem[64]  <= 32'hDEAD_BEEF;
         mem[65]  <= 32'h0000_0000;
         mem[128] <= 32'h1111_1111;
      end else if (ram_en && ram_we) begin
         mem[ram_addr[9:2]] <= ram_wdata;
      end
      pipe1     <= (ram_en && !ram_we) ? mem[ram_addr[9:2]] : 32'hA5A5_A5A5;
      ram_rdata <= pipe1;
   end

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge Clk) begin
      if (Reset) begin
         if (if_done) begin
            check("if_stall_on_done", {31'b0, if_stall}, 32'd0);
            if (if_q.size() == 0) begin
               check("if_done_spurious", {31'b0, if_done}, 32'd0);
            end else begin
               if_e = if_q.pop_front();
               check("if_done_cycle", 32'(cyc), 32'(if_e.cyc));
               if (if_e.chk) check("if_rdata", if_rdata, if_e.data);
            end
         end
         if (mem_done) begin
            check("mem_stall_on_done", {31'b0, mem_stall}, 32'd0);
            if (mem_q.size() == 0) begin
               check("mem_done_spurious", {31'b0, mem_done}, 32'd0);
            end else begin
               mem_e = mem_q.pop_front();
               check("mem_done_cycle", 32'(cyc), 32'(mem_e.cyc));
               if (mem_e.chk) check("mem_rdata", mem_rdata, mem_e.data);
            end
         end
      end
   end

   task automatic run_if(input logic [31:0] a);
      int n = 0;
      if_req  = 1'b1;
      if_addr = a;
      while (1) begin
         @(negedge Clk);
         if (if_done) break;
         n++;
         if (n > 40) begin
            check("if_done_timeout", {31'b0, if_done}, 32'd1);
            break;
         end
      end
      @(posedge Clk);
      #1;
      if_req = 1'b0;
   endtask

   task automatic run_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      mem_req   = 1'b1;
      mem_we    = we;
      mem_addr  = a;
      mem_wdata = d;
      while (1) begin
         @(negedge Clk);
         if (mem_done) break;
         n++;
         if (n > 40) begin
            check("mem_done_timeout", {31'b0, mem_done}, 32'd1);
            break;
         end
      end
      @(posedge Clk);
      #1;
      mem_req = 1'b0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ram_en"}, {31'b0, ram_en}, 32'd0);
      check({tag, "_ram_we"}, {31'b0, ram_we}, 32'd0);
      check({tag, "_ram_addr"}, ram_addr, 32'd0);
      check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
      check({tag, "_if_rdata"}, if_rdata, 32'd0);
      check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
      check({tag, "_if_done"}, {31'b0, if_done}, 32'd0);
      check({tag, "_mem_done"}, {31'b0, mem_done}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0;
      int t1;

      // Reset state.
      repeat (3) @(posedge Clk);
      #1;
      check_outputs_zero("reset");
      Reset = 1'b1;
      step();

      // Single IF fetch: ram_en one cycle after the request, done 4 cycles after.
      t0 = cyc;
      if_q.push_back('{data: 32'h8C02_0004, chk: 1'b1, cyc: t0 + 4});
      fork
         run_if(32'h40);
         begin
            #1;
            check("if_stall_pending", {31'b0, if_stall}, 32'd1);
            @(negedge Clk);
            check("ram_en_grant_cycle", {31'b0, ram_en}, 32'd0);
            @(negedge Clk);
            check("ram_en_issue", {31'b0, ram_en}, 32'd1);
            check("ram_addr_issue", ram_addr, 32'h40);
            check("ram_we_fetch", {31'b0, ram_we}, 32'd0);
            @(negedge Clk);
            check("ram_en_one_cycle", {31'b0, ram_en}, 32'd0);
            check("ram_addr_hold", ram_addr, 32'h40);
         end
      join
      step();

      // Simultaneous requests: MEM wins, IF follows one access period later.
      t0 = cyc;
      mem_q.push_back('{data: 32'hDEAD_BEEF, chk: 1'b1, cyc: t0 + 4});
      if_q.push_back('{data: 32'h1111_1111, chk: 1'b1, cyc: t0 + 9});
      fork
         run_mem(1'b0, 32'h100, 32'h0);
         run_if(32'h200);
         begin
            repeat (5) @(negedge Clk);
            check("if_stall_while_mem_done", {31'b0, if_stall}, 32'd1);
         end
      join
      check("if_rdata_hold", if_rdata, 32'h1111_1111);
      check("mem_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
      step();

      // Store then load of the same address.
      t0 = cyc;
`ifdef WB_BUFFER_EN
      mem_q.push_back('{data: 32'h0, chk: 1'b0, cyc: t0 + 1});
`else
      mem_q.push_back('{data: 32'h0, chk: 1'b0, cyc: t0 + 4});
`endif
      fork
         run_mem(1'b1, 32'h104, 32'h1234_5678);
         begin
            int n = 0;
            while (n < 20) begin
               @(negedge Clk);
               if (ram_en) break;
               n++;
            end
            check("store_ram_en", {31'b0, ram_en}, 32'd1);
            check("store_ram_we", {31'b0, ram_we}, 32'd1);
            check("store_ram_addr", ram_addr, 32'h104);
            check("store_ram_wdata", ram_wdata, 32'h1234_5678);
         end
      join
      check("store_keeps_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
      t1 = cyc;
`ifdef WB_BUFFER_EN
      mem_q.push_back('{data: 32'h1234_5678, chk: 1'b1, cyc: t1 + 8});
`else
      mem_q.push_back('{data: 32'h1234_5678, chk: 1'b1, cyc: t1 + 4});
`endif
      run_mem(1'b0, 32'h104, 32'h0);
      step();

      // Flush: IF drops its request during WAIT; no done, FSM idle on schedule.
      t0 = cyc;
      if_req  = 1'b1;
      if_addr = 32'h40;
      step();
      step();
      if_req = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         check("flush_no_if_done", {31'b0, if_done}, 32'd0);
         step();
      end
      mem_q.push_back('{data: 32'hDEAD_BEEF, chk: 1'b1, cyc: t0 + 9});
      fork
         run_mem(1'b0, 32'h100, 32'h0);
         begin
            @(negedge Clk);
            check("flush_idle_no_ram_en", {31'b0, ram_en}, 32'd0);
            @(negedge Clk);
            check("flush_next_ram_en", {31'b0, ram_en}, 32'd1);
            check("flush_next_ram_addr", ram_addr, 32'h100);
         end
      join
      check("flush_if_rdata_hold", if_rdata, 32'h1111_1111);
      step();

      // Reset asserted mid-WAIT with an IF fetch in flight.
      if_req  = 1'b1;
      if_addr = 32'h40;
      step();
      step();
      #2;
      Reset = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      if_req = 1'b0;
      step();
      Reset = 1'b1;
      repeat (6) begin
         @(negedge Clk);
         check("post_reset_no_if_done", {31'b0, if_done}, 32'd0);
         check("post_reset_no_ram_en", {31'b0, ram_en}, 32'd0);
      end

      check("if_queue_drained", 32'(if_q.size()), 32'd0);
      check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
